// File: rtl/mem_access_lsu.sv
// Memory-stage load/store unit: initiates data-bus transactions, formats store lanes,
// extends load data and forwards the control bundle to writeback with bubbles while busy.
module mem_access_lsu #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned TIMEOUT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    input  logic        in_MemToReg,
    input  logic        in_RegWrite,
    input  logic [4:0]  in_RegDest,
    input  logic        in_PCSrc,
    input  logic [31:0] in_BranchTarget,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_mem,
    output logic [31:0] result_alu,
    output logic        out_MemToReg,
    output logic        out_RegWrite,
    output logic [4:0]  out_RegDest,
    output logic        out_PCSrc,
    output logic [31:0] out_BranchTarget,
    output logic        stall_out,
    output logic        bus_error
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state_q;
    logic [TIMEOUT_W-1:0] cnt_q;

    logic        load_q, timeout_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, target_q, ldata_q;
    logic        memtoreg_q, regwrite_q, pcsrc_q;
    logic [4:0]  regdest_q;

    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic [31:0] data_mem_q, result_alu_q, out_BranchTarget_q;
    logic        out_MemToReg_q, out_RegWrite_q, out_PCSrc_q, bus_error_q;
    logic [4:0]  out_RegDest_q;

    logic        is_mem, aligned;
    logic [31:0] st_wdata, ld_ext;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_mem = in_MemRead | in_MemWrite;

    // funct3[1:0] gives the access size; encodings 10 and 11 both behave as a word
    always_comb begin
        aligned  = 1'b1;
        st_wdata = in_store_data;
        st_be    = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_store_data[7:0]}};
                st_be    = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                aligned  = ~in_addr[0];
                st_wdata = {2{in_store_data[15:0]}};
                st_be    = 4'b0011 << in_addr[1:0];
            end
            default: aligned = (in_addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext  = mem_rdata;
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Gated by rst so every output reads 0 while reset is held.
    always_comb begin
        stall_out = 1'b0;
        case (state_q)
            IDLE:    stall_out = is_mem & aligned & ~stall;
            BUSY:    stall_out = 1'b1;
            DONE:    stall_out = stall;
            default: stall_out = 1'b0;
        endcase
        if (rst) stall_out = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            load_q             <= 1'b0;
            timeout_q          <= 1'b0;
            funct3_q           <= '0;
            addr_q             <= '0;
            target_q           <= '0;
            ldata_q            <= '0;
            memtoreg_q         <= 1'b0;
            regwrite_q         <= 1'b0;
            pcsrc_q            <= 1'b0;
            regdest_q          <= '0;
            mem_req_q          <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= '0;
            mem_wdata_q        <= '0;
            mem_be_q           <= '0;
            data_mem_q         <= '0;
            result_alu_q       <= '0;
            out_BranchTarget_q <= '0;
            out_MemToReg_q     <= 1'b0;
            out_RegWrite_q     <= 1'b0;
            out_PCSrc_q        <= 1'b0;
            out_RegDest_q      <= '0;
            bus_error_q        <= 1'b0;
        end else begin
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        if (!is_mem) begin
                            result_alu_q       <= in_addr;
                            out_MemToReg_q     <= in_MemToReg;
                            out_RegWrite_q     <= in_RegWrite;
                            out_RegDest_q      <= in_RegDest;
                            out_PCSrc_q        <= in_PCSrc;
                            out_BranchTarget_q <= in_BranchTarget;
                        end else begin
                            out_RegWrite_q <= 1'b0;
                            out_PCSrc_q    <= 1'b0;
                            if (!aligned) begin
                                bus_error_q <= 1'b1;
                            end else begin
                                load_q      <= in_MemRead & ~in_MemWrite;
                                funct3_q    <= in_funct3;
                                addr_q      <= in_addr;
                                target_q    <= in_BranchTarget;
                                memtoreg_q  <= in_MemToReg;
                                regwrite_q  <= in_RegWrite;
                                pcsrc_q     <= in_PCSrc;
                                regdest_q   <= in_RegDest;
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= in_MemWrite;
                                mem_addr_q  <= {in_addr[31:2], 2'b00};
                                mem_wdata_q <= st_wdata;
                                mem_be_q    <= st_be;
                                cnt_q       <= '0;
                                state_q     <= BUSY;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        if (load_q) ldata_q <= ld_ext;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q   <= 1'b0;
                        cnt_q       <= '0;
                        timeout_q   <= 1'b1;
                        ldata_q     <= '0;
                        bus_error_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + TIMEOUT_W'(1);
                    end
                end
                DONE: begin
                    if (!stall) begin
                        result_alu_q       <= addr_q;
                        out_MemToReg_q     <= memtoreg_q;
                        out_RegWrite_q     <= regwrite_q & ~timeout_q;
                        out_RegDest_q      <= regdest_q;
                        out_PCSrc_q        <= pcsrc_q;
                        out_BranchTarget_q <= target_q;
                        if (load_q || timeout_q) data_mem_q <= ldata_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_be           = mem_be_q;
    assign data_mem         = data_mem_q;
    assign result_alu       = result_alu_q;
    assign out_MemToReg     = out_MemToReg_q;
    assign out_RegWrite     = out_RegWrite_q;
    assign out_RegDest      = out_RegDest_q;
    assign out_PCSrc        = out_PCSrc_q;
    assign out_BranchTarget = out_BranchTarget_q;
    assign bus_error        = bus_error_q;

endmodule

// File: tb/tb_mem_access_lsu.sv
// Self-checking bench for mem_access_lsu: directed cases plus randomized operations
// scored against a transaction-level memory/writeback model.
module tb_mem_access_lsu;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, in_MemRead, in_MemWrite;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_store_data;
    logic        in_MemToReg, in_RegWrite, in_PCSrc;
    logic [4:0]  in_RegDest;
    logic [31:0] in_BranchTarget;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] data_mem, result_alu, out_BranchTarget;
    logic        out_MemToReg, out_RegWrite, out_PCSrc, stall_out, bus_error;
    logic [4:0]  out_RegDest;

    always #5 clk = ~clk;

    mem_access_lsu #(.TIMEOUT(TO), .TIMEOUT_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_store_data(in_store_data),
        .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest),
        .in_PCSrc(in_PCSrc), .in_BranchTarget(in_BranchTarget),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .data_mem(data_mem), .result_alu(result_alu),
        .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest),
        .out_PCSrc(out_PCSrc), .out_BranchTarget(out_BranchTarget),
        .stall_out(stall_out), .bus_error(bus_error)
    );

    int unsigned n_chk, n_fail;
    logic [31:0] mem [64];
    // Architectural view of the writeback-facing registers
    logic [31:0] e_dm, e_alu, e_bt;
    logic        e_m2r, e_rw, e_pcs;
    logic [4:0]  e_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".data_mem"}, data_mem, e_dm);
        chk({tag, ".result_alu"}, result_alu, e_alu);
        chk({tag, ".MemToReg"}, 32'(out_MemToReg), 32'(e_m2r));
        chk({tag, ".RegWrite"}, 32'(out_RegWrite), 32'(e_rw));
        chk({tag, ".RegDest"}, 32'(out_RegDest), 32'(e_rd));
        chk({tag, ".PCSrc"}, 32'(out_PCSrc), 32'(e_pcs));
        chk({tag, ".BranchTarget"}, out_BranchTarget, e_bt);
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        int unsigned sz;
        logic [31:0] v, mask;
        sz = size_of(f3);
        v  = w >> (8 * a);
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input int unsigned sz, input logic [1:0] a);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic logic [31:0] ref_wd(input int unsigned sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // One instruction through the stage; ack_dly >= TO means the bus never answers.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_dly, input int done_stl, input int idle_stl);
        int unsigned sz;
        logic        mop, al, tmo, rw, pcs, m2r;
        logic [4:0]  rdst;
        logic [31:0] bt, word, wd;
        logic [3:0]  be;
        logic [5:0]  idx;
        sz   = size_of(f3);
        mop  = rd | wr;
        al   = (a[1:0] % sz) == 0;
        rw   = wr ? 1'b0 : 1'($urandom);
        pcs  = 1'($urandom);
        m2r  = 1'($urandom);
        rdst = 5'($urandom);
        bt   = $urandom;
        idx  = a[7:2];
        be   = ref_be(sz, a[1:0]);
        wd   = ref_wd(sz, sd);

        in_MemRead = rd; in_MemWrite = wr; in_funct3 = f3; in_addr = a; in_store_data = sd;
        in_RegWrite = rw; in_PCSrc = pcs; in_MemToReg = m2r; in_RegDest = rdst;
        in_BranchTarget = bt;

        for (int k = 0; k < idle_stl; k++) begin
            stall = 1'b1; mem_ack = 1'($urandom); mem_rdata = $urandom;
            step();
            chk("idle_stall.req", 32'(mem_req), 32'(1'b0));
            chk_outs("idle_stall");
        end

        stall = 1'b0; mem_ack = 1'($urandom); mem_rdata = $urandom;
        #1;
        if (!mop) begin
            chk("alu.stall_out", 32'(stall_out), 32'(1'b0));
            step();
            e_alu = a; e_m2r = m2r; e_rw = rw; e_rd = rdst; e_pcs = pcs; e_bt = bt;
            chk_outs("alu");
            chk("alu.bus_error", 32'(bus_error), 32'(1'b0));
            chk("alu.req", 32'(mem_req), 32'(1'b0));
            return;
        end
        if (!al) begin
            chk("misal.stall_out", 32'(stall_out), 32'(1'b0));
            step();
            e_rw = 1'b0; e_pcs = 1'b0;
            chk_outs("misal");
            chk("misal.bus_error", 32'(bus_error), 32'(1'b1));
            chk("misal.req", 32'(mem_req), 32'(1'b0));
            stall = 1'b1; mem_ack = 1'b0;
            step();
            chk("misal.pulse_end", 32'(bus_error), 32'(1'b0));
            chk("misal.req2", 32'(mem_req), 32'(1'b0));
            chk_outs("misal_after");
            return;
        end

        chk("accept.stall_out", 32'(stall_out), 32'(1'b1));
        chk("accept.req", 32'(mem_req), 32'(1'b0));
        step();
        e_rw = 1'b0; e_pcs = 1'b0;
        word = mem[idx];
        tmo  = 1'b1;
        for (int i = 0; i < int'(TO); i++) begin
            stall = 1'($urandom); mem_ack = 1'b0; mem_rdata = $urandom;
            chk("busy.req", 32'(mem_req), 32'(1'b1));
            chk("busy.we", 32'(mem_we), 32'(wr));
            chk("busy.addr", mem_addr, {a[31:2], 2'b00});
            chk("busy.be", 32'(mem_be), 32'(be));
            if (wr) chk("busy.wdata", mem_wdata, wd);
            chk("busy.stall_out", 32'(stall_out), 32'(1'b1));
            chk("busy.bus_error", 32'(bus_error), 32'(1'b0));
            chk_outs("busy");
            if (i == ack_dly) begin
                mem_ack = 1'b1; mem_rdata = word; tmo = 1'b0;
                step();
                mem_ack = 1'b0;
                break;
            end
            step();
        end
        if (!tmo && wr)
            for (int j = 0; j < 4; j++)
                if (be[j]) mem[idx][8 * j +: 8] = wd[8 * j +: 8];

        chk("done.req", 32'(mem_req), 32'(1'b0));
        chk("done.bus_error", 32'(bus_error), 32'(tmo));
        for (int k = 0; k < done_stl; k++) begin
            stall = 1'b1; mem_ack = 1'($urandom); mem_rdata = $urandom;
            #1;
            chk("done_stall.stall_out", 32'(stall_out), 32'(1'b1));
            step();
            chk_outs("done_stall");
            chk("done_stall.req", 32'(mem_req), 32'(1'b0));
            chk("done_stall.bus_error", 32'(bus_error), 32'(1'b0));
        end
        stall = 1'b0; mem_ack = 1'b0;
        #1;
        chk("done.stall_out", 32'(stall_out), 32'(1'b0));
        step();
        e_alu = a; e_m2r = m2r; e_rw = rw & ~tmo; e_rd = rdst; e_pcs = pcs; e_bt = bt;
        if (tmo) e_dm = '0;
        else if (rd && !wr) e_dm = ref_load(f3, a[1:0], word);
        chk_outs("wb");
        chk("wb.bus_error", 32'(bus_error), 32'(1'b0));
        chk("wb.req", 32'(mem_req), 32'(1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3s [8];
        n_chk = 0; n_fail = 0;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
        rst = 1'b1; stall = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_funct3 = '0;
        in_addr = '0; in_store_data = '0; in_MemToReg = 1'b0; in_RegWrite = 1'b0;
        in_RegDest = '0; in_PCSrc = 1'b0; in_BranchTarget = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        e_dm = '0; e_alu = '0; e_bt = '0; e_m2r = 1'b0; e_rw = 1'b0; e_pcs = 1'b0; e_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset");
        chk("reset.req", 32'(mem_req), 32'(1'b0));
        chk("reset.stall_out", 32'(stall_out), 32'(1'b0));
        chk("reset.bus_error", 32'(bus_error), 32'(1'b0));
        chk("reset.addr", mem_addr, 32'h0);
        chk("reset.be", 32'(mem_be), 32'h0);
        rst = 1'b0;

        mem[0] = 32'hDEAD_BEEF;
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0);
        chk("lw.const", data_mem, 32'hDEAD_BEEF);
        mem[0] = 32'h80FF_FF7F;
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 0);
        chk("lb.const", data_mem, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 0);
        chk("lbu.const", data_mem, 32'h0000_0080);
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 1);
        chk("lh.const", data_mem, 32'hFFFF_80FF);
        run_op(1'b0, 1'b1, 3'b000, 32'h0A2, 32'h1234_5678, 0, 0, 0);
        run_op(1'b0, 1'b1, 3'b001, 32'h0A2, 32'h1234_5678, 2, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, int'(TO), 0, 0);
        chk("timeout.const", data_mem, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, int'(TO) - 1, 0, 0);
        run_op(1'b1, 1'b0, 3'b000, 32'h10C, 32'h0, 1, 3, 1);
        run_op(1'b1, 1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 0, 1, 0);

        in_MemRead = 1'b1; in_MemWrite = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40;
        stall = 1'b0; mem_ack = 1'b0;
        step();
        chk("rst_busy.req_before", 32'(mem_req), 32'(1'b1));
        rst = 1'b1;
        #1;
        e_dm = '0; e_alu = '0; e_bt = '0; e_m2r = 1'b0; e_rw = 1'b0; e_pcs = 1'b0; e_rd = '0;
        chk_outs("rst_busy");
        chk("rst_busy.req", 32'(mem_req), 32'(1'b0));
        chk("rst_busy.we", 32'(mem_we), 32'(1'b0));
        chk("rst_busy.addr", mem_addr, 32'h0);
        chk("rst_busy.wdata", mem_wdata, 32'h0);
        chk("rst_busy.be", 32'(mem_be), 32'h0);
        chk("rst_busy.stall_out", 32'(stall_out), 32'(1'b0));
        chk("rst_busy.bus_error", 32'(bus_error), 32'(1'b0));
        step();
        rst = 1'b0;

        for (int n = 0; n < 250; n++) begin
            int unsigned k, r, dly, ds, is;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            k  = $urandom_range(0, 99);
            rd = (k < 35) || (k >= 90);
            wr = (k >= 35 && k < 65) || (k >= 90);
            f3 = f3s[$urandom_range(0, 7)];
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
            r = $urandom_range(0, 19);
            if (r < 14)       dly = r % 4;
            else if (r < 17)  dly = $urandom_range(4, TO - 1);
            else if (r == 17) dly = TO - 1;
            else              dly = TO;
            ds = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            is = ($urandom_range(0, 4) == 0) ? 1 : 0;
            run_op(rd, wr, f3, a, $urandom, int'(dly), int'(ds), int'(is));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_lsu.md
Name: mem_access_lsu

Overview:
- Memory-stage load/store unit of the 5-stage CPU, between execute and writeback.
- Acts as initiator on the data-memory req/ack bus and produces the aligned, extended load data that writeback selects with MemToReg.
- Stalls the front of the pipeline while a bus transaction is outstanding.
- Forwards the control bundle to writeback, inserting bubbles while busy.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay unacknowledged before abort
TIMEOUT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  downstream/global hold
in_MemRead  in  1  load op
in_MemWrite  in  1  store op
in_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  32  effective address (ALU result)
in_store_data  in  32  rs2 value
in_MemToReg  in  1  passthrough
in_RegWrite  in  1  passthrough
in_RegDest  in  5  passthrough
in_PCSrc  in  1  passthrough
in_BranchTarget  in  32  passthrough
mem_req  out  1  bus request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  word address, bits[1:0] = 0
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  one-cycle completion strobe
mem_rdata  in  32  read word, valid with mem_ack
data_mem  out  32  extended load result
result_alu  out  32  registered in_addr
out_MemToReg  out  1  registered
out_RegWrite  out  1  registered
out_RegDest  out  5  registered
out_PCSrc  out  1  registered
out_BranchTarget  out  32  registered
stall_out  out  1  upstream must hold inputs
bus_error  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs are 0 on reset; FSM is IDLE; timeout counter is 0. Reset mid-transaction drops mem_req immediately, with no completion.
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-memory op, stall=0: outputs register the inputs next edge (1-cycle latency); data_mem is unchanged; stall_out=0.
- IDLE, memory op, stall=0, aligned: stall_out=1 combinationally; latch addr/be/wdata/we and the control bundle; go to BUSY. Output registers load a bubble: out_RegWrite=0, out_PCSrc=0; other fields hold.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
- Misaligned access: no bus request. On the next edge, issue a bubble plus a bus_error pulse for one cycle; stall_out=0.
- Both in_MemRead and in_MemWrite high: treat as a store.
- BUSY: mem_req=1 with stable mem_we/addr/wdata/be; stall_out=1; the counter increments each cycle.
  - mem_ack: capture extended load data (loads only); go to DONE. The counter clears.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, pulse bus_error, go to DONE with data_mem=0 and out_RegWrite forced 0.
- DONE:
  - stall=0: output registers load the latched bundle plus data_mem; go to IDLE; stall_out=0 this cycle, so upstream advances on this same edge.
  - stall=1: hold DONE with stall_out=1.
- Total load latency with no wait states: request visible the cycle after accept; ack same cycle gives 3 cycles accept-to-writeback.
- Stores:
  - mem_wdata = B: {4{byte}}, H: {2{half}}, W: word.
  - mem_be = B: 0001<<addr[1:0]; H: 0011<<addr[1:0]; W: 1111.
- Loads: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend. Any other funct3 is treated as W.
- stall=1 in IDLE: no acceptance; output registers hold. stall has no effect in BUSY; the bus handshake still completes.
- mem_ack outside BUSY is ignored.

Test Plan:
- Aligned LW addr 0x100, mem_rdata 0xDEADBEEF, ack in first BUSY cycle -> mem_req 1 cycle, mem_addr 0x100, mem_be 1111; data_mem 0xDEADBEEF with out_RegWrite=1 three edges after accept; stall_out high 2 cycles.
- LB addr 0x103, rdata 0x80FF_FF7F -> data_mem 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x0A2, data 0x12345678 -> mem_we=1, mem_be 0100, mem_wdata 0x78787878, out_RegWrite=0. SH addr 0x0A2 -> be 1100, wdata 0x56785678.
- LW addr 0x101 -> no mem_req, bus_error pulses 1 cycle, out_RegWrite=0, stall_out never asserted.
- No ack for TIMEOUT=16 cycles -> mem_req drops, bus_error pulse, data_mem=0, pipeline resumes.
- Ack while stall=1 -> FSM holds in DONE, outputs unchanged. When stall falls, outputs update exactly once. Separately: assert rst mid-BUSY -> mem_req=0 immediately and all outputs 0.
